// File: rtl/hazard_pkg.sv
// Shared defaults and types for the register-hazard scoreboard.
package hazard_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;
  localparam int MAX_LAT    = 4;
  localparam int LAT_W      = 3;
  localparam int STAT_W     = 16;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [LAT_W-1:0]      lat_t;
endpackage

// File: rtl/hazard_sb_entry.sv
// One per-register writeback countdown: load on issue, otherwise count down to zero and hold.
module hazard_sb_entry
  import hazard_pkg::*;
#(
  parameter int CNT_W = hazard_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_busy,
  output logic             o_is_one
);
  logic [CNT_W-1:0] r_cnt;

  // A fresh issue overrides the decrement of an older pending write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_load_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - CNT_W'(1);
  end

  assign o_cnt    = r_cnt;
  assign o_busy   = (r_cnt != '0);
  assign o_is_one = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage scoreboard of pending writebacks with variable result latency.
// Optional HAZARD_FWD_EN: a source in its final countdown cycle is taken from the bypass bus.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int MAX_LAT    = hazard_pkg::MAX_LAT,
  parameter int LAT_W      = hazard_pkg::LAT_W,
  parameter int STAT_W     = hazard_pkg::STAT_W,
  parameter int NUM_REGS   = 2 ** REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  two_src,
  input  logic [REG_ADDR_W-1:0] dest,
  input  logic                  wb_en,
  input  logic [LAT_W-1:0]      wb_lat,
  input  logic                  flush,
  output logic                  hazard_detected,
  output logic                  fwd1,
  output logic                  fwd2,
  output logic [NUM_REGS-1:0]   busy_mask,
  output logic [STAT_W-1:0]     stall_cnt
);
  logic [LAT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_is_one;
  logic [NUM_REGS-1:0] w_load;
  logic [LAT_W-1:0]    w_lat_eff;
  logic                w_src1_ready;
  logic                w_src2_ready;
  logic                w_waw;
  logic                w_issue;
  logic [STAT_W-1:0]   r_stall_cnt;

  assign w_lat_eff = (wb_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : wb_lat;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_entry
      assign w_load[gi] = w_issue & wb_en & (w_lat_eff != '0) & (dest == REG_ADDR_W'(gi));
      hazard_sb_entry #(.CNT_W(LAT_W)) u_entry (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load[gi]),
        .i_load_val (w_lat_eff),
        .o_cnt      (w_cnt[gi]),
        .o_busy     (busy_mask[gi]),
        .o_is_one   (w_is_one[gi])
      );
    end
  endgenerate

`ifdef HAZARD_FWD_EN
  assign w_src1_ready = (w_cnt[src1] <= LAT_W'(1));
  assign w_src2_ready = (w_cnt[src2] <= LAT_W'(1));
  assign fwd1 = w_issue & w_is_one[src1];
  assign fwd2 = w_issue & two_src & w_is_one[src2];
`else
  logic w_unused_is_one;
  assign w_unused_is_one = ^w_is_one;
  assign w_src1_ready = (w_cnt[src1] == '0);
  assign w_src2_ready = (w_cnt[src2] == '0);
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  // A later write must not land before an older, slower one to the same register.
  assign w_waw = wb_en & (w_cnt[dest] > w_lat_eff);

  assign hazard_detected = issue_valid & ~flush &
                           (~w_src1_ready | (two_src & ~w_src2_ready) | w_waw);
  assign w_issue = issue_valid & ~flush & ~hazard_detected;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (hazard_detected && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + STAT_W'(1);
  end

  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard, plus reset sequences.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  typedef struct {
    logic       iv;
    int         s1;
    int         s2;
    logic       two;
    int         d;
    logic       wbe;
    int         lat;
    logic       fl;
    logic       e_hz;
    logic [15:0] e_busy;
    logic       e_f1;
    logic       e_f2;
    int         e_stall;
  } vec_t;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                issue_valid = 1'b0;
  reg_addr_t           src1 = '0;
  reg_addr_t           src2 = '0;
  logic                two_src = 1'b0;
  reg_addr_t           dest = '0;
  logic                wb_en = 1'b0;
  lat_t                wb_lat = '0;
  logic                flush = 1'b0;
  logic                hazard_detected;
  logic                fwd1;
  logic                fwd2;
  logic [NUM_REGS-1:0] busy_mask;
  logic [STAT_W-1:0]   stall_cnt;

  int checks = 0;
  int failures = 0;
  vec_t tbl [64];
  int n_vec = 0;

  hazard_scoreboard dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .src1            (src1),
    .src2            (src2),
    .two_src         (two_src),
    .dest            (dest),
    .wb_en           (wb_en),
    .wb_lat          (wb_lat),
    .flush           (flush),
    .hazard_detected (hazard_detected),
    .fwd1            (fwd1),
    .fwd2            (fwd2),
    .busy_mask       (busy_mask),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic int pk(input int d, input int f);
    return FWD ? f : d;
  endfunction

  function automatic void add(input logic iv, input int s1, input int s2, input logic two,
                              input int d, input logic wbe, input int lat, input logic fl,
                              input logic e_hz, input logic [15:0] e_busy, input logic e_f1,
                              input logic e_f2, input int e_stall);
    tbl[n_vec] = '{iv, s1, s2, two, d, wbe, lat, fl, e_hz, e_busy, e_f1, e_f2, e_stall};
    n_vec++;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=0x%0h want=0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input int s1, input int s2, input logic two,
                       input int d, input logic wbe, input int lat, input logic fl);
    issue_valid = iv;
    src1        = reg_addr_t'(s1);
    src2        = reg_addr_t'(s2);
    two_src     = two;
    dest        = reg_addr_t'(d);
    wb_en       = wbe;
    wb_lat      = lat_t'(lat);
    flush       = fl;
  endtask

  initial begin
    // back-to-back RAW on a latency-3 result
    add(1,0,0,0,2,1,3,0, 0,16'h0000,0,0,0);
    add(1,2,0,0,0,0,0,0, 1,16'h0004,0,0,0);
    add(1,2,0,0,0,0,0,0, 1,16'h0004,0,0,1);
    add(1,2,0,0,0,0,0,0, 1'(pk(1,0)),16'h0004,1'(pk(0,1)),0,2);
    add(1,2,0,0,0,0,0,0, 0,16'h0000,0,0,pk(3,2));
    // src2 only counts when two_src is set
    add(1,0,0,0,5,1,1,0, 0,16'h0000,0,0,pk(3,2));
    add(1,0,5,0,0,0,0,0, 0,16'h0020,0,0,pk(3,2));
    add(1,0,0,0,5,1,1,0, 0,16'h0000,0,0,pk(3,2));
    add(1,0,5,1,0,0,0,0, 1'(pk(1,0)),16'h0020,0,1'(pk(0,1)),pk(3,2));
    add(1,0,5,1,0,0,0,0, 0,16'h0000,0,0,pk(4,2));
    // WAW: short write behind a long one
    add(1,0,0,0,4,1,3,0, 0,16'h0000,0,0,pk(4,2));
    add(1,0,0,0,4,1,1,0, 1,16'h0010,0,0,pk(4,2));
    add(1,0,0,0,4,1,1,0, 1,16'h0010,0,0,pk(5,3));
    add(1,0,0,0,4,1,1,0, 0,16'h0010,0,0,pk(6,4));
    add(0,0,0,0,0,0,0,0, 0,16'h0010,0,0,pk(6,4));
    // latency clamp and zero latency
    add(1,0,0,0,6,1,7,0, 0,16'h0000,0,0,pk(6,4));
    add(0,0,0,0,0,0,0,0, 0,16'h0040,0,0,pk(6,4));
    add(0,0,0,0,0,0,0,0, 0,16'h0040,0,0,pk(6,4));
    add(0,0,0,0,0,0,0,0, 0,16'h0040,0,0,pk(6,4));
    add(0,0,0,0,0,0,0,0, 0,16'h0040,0,0,pk(6,4));
    add(1,0,0,0,7,1,0,0, 0,16'h0000,0,0,pk(6,4));
    add(0,0,0,0,0,0,0,0, 0,16'h0000,0,0,pk(6,4));
    // latency-2 dependency (forwarding case)
    add(1,0,0,0,1,1,2,0, 0,16'h0000,0,0,pk(6,4));
    add(1,1,0,0,0,0,0,0, 1,16'h0002,0,0,pk(6,4));
    add(1,1,0,0,0,0,0,0, 1'(pk(1,0)),16'h0002,1'(pk(0,1)),0,pk(7,5));
    add(1,1,0,0,0,0,0,0, 0,16'h0000,0,0,pk(8,5));
    // flush on a hazard cycle: no stall, no counter write
    add(1,0,0,0,3,1,2,0, 0,16'h0000,0,0,pk(8,5));
    add(1,3,0,0,8,1,3,1, 0,16'h0008,0,0,pk(8,5));
    add(0,0,0,0,0,0,0,0, 0,16'h0008,0,0,pk(8,5));
    add(0,0,0,0,0,0,0,0, 0,16'h0000,0,0,pk(8,5));

    drive(1,0,0,0,0,0,0,0);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", -1, 32'(busy_mask), 32'h0);
    chk("rst_hz", -1, 32'(hazard_detected), 32'h0);
    chk("rst_stall", -1, 32'(stall_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < n_vec; i++) begin
      drive(tbl[i].iv, tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].d, tbl[i].wbe, tbl[i].lat, tbl[i].fl);
      #1;
      $display("vec %0d: iv=%0b s1=%0d s2=%0d two=%0b d=%0d wbe=%0b lat=%0d fl=%0b -> hz=%0b busy=%04h f1=%0b f2=%0b stall=%0d",
               i, tbl[i].iv, tbl[i].s1, tbl[i].s2, tbl[i].two, tbl[i].d, tbl[i].wbe, tbl[i].lat,
               tbl[i].fl, hazard_detected, busy_mask, fwd1, fwd2, stall_cnt);
      chk("hazard", i, 32'(hazard_detected), 32'(tbl[i].e_hz));
      chk("busy_mask", i, 32'(busy_mask), 32'(tbl[i].e_busy));
      chk("fwd1", i, 32'(fwd1), 32'(tbl[i].e_f1));
      chk("fwd2", i, 32'(fwd2), 32'(tbl[i].e_f2));
      chk("stall_cnt", i, 32'(stall_cnt), 32'(tbl[i].e_stall));
      @(negedge clk);
    end

    // asynchronous reset while R3 is pending
    drive(1,0,0,0,3,1,3,0);
    @(negedge clk);
    drive(0,0,0,0,0,0,0,0);
    #1;
    chk("pre_rst_busy", 100, 32'(busy_mask), 32'h0008);
    chk("pre_rst_stall", 100, 32'(stall_cnt), 32'(pk(8,5)));
    drive(1,3,0,0,0,0,0,0);
    #1;
    chk("pre_rst_hz", 100, 32'(hazard_detected), 32'h1);
    rst = 1'b0;
    #1;
    $display("async reset: busy=%04h hz=%0b stall=%0d", busy_mask, hazard_detected, stall_cnt);
    chk("arst_busy", 101, 32'(busy_mask), 32'h0);
    chk("arst_hz", 101, 32'(hazard_detected), 32'h0);
    chk("arst_stall", 101, 32'(stall_cnt), 32'h0);
    chk("arst_fwd1", 101, 32'(fwd1), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_busy", 102, 32'(busy_mask), 32'h0);
    chk("post_rst_hz", 102, 32'(hazard_detected), 32'h0);
    @(negedge clk);
    #1;
    chk("post_rst_stall", 103, 32'(stall_cnt), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
